// File: rtl/x86_pkg.sv
// Shared register-file widths and the write-back entry layout.
package x86_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] idx;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: searches the pending write-back entries for one register index.
// Latency: purely combinational. Backpressure: none, a lookup only.
module wb_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] i_regs,
    input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [PTR_W-1:0]             i_head,
    input  logic [ADDR_W-1:0]            i_query,
    output logic                         o_hit,
    output logic [DATA_W-1:0]            o_data
);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if (i_valid[w_idx] && (i_regs[w_idx] == i_query)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: in-order FIFO draining execute results into the register file write port.
// Latency: accepted at edge N, shown on rf_* after N, written at N+1 unless rf_stall.
// Backpressure: in_ready low when full or in reset; rf_stall holds the head. WB_FORWARD_EN adds fwd_* lookup.
module writeback_queue
    import x86_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       in_reg,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    rf_stall,
    output logic                    rf_write,
    output logic [ADDR_W-1:0]       rf_w_ctrl,
    output logic [DATA_W-1:0]       rf_w_data,
    output logic [$clog2(DEPTH):0]  count
`ifdef WB_FORWARD_EN
    ,
    input  logic [ADDR_W-1:0]       fwd_ctrl0,
    input  logic [ADDR_W-1:0]       fwd_ctrl1,
    output logic                    fwd_hit0,
    output logic                    fwd_hit1,
    output logic [DATA_W-1:0]       fwd_data0,
    output logic [DATA_W-1:0]       fwd_data1
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] r_regs;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;
    logic [PTR_W-1:0]             r_head;
    logic [PTR_W-1:0]             r_tail;
    logic [CNT_W-1:0]             r_count;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_nonempty;

    // Reset masks the head so nothing reaches the register file on the reset edge.
    assign w_nonempty = (r_count != '0) && !rst;
    assign in_ready   = (r_count != CNT_W'(DEPTH)) && !rst;
    assign rf_write   = w_nonempty && !rf_stall;
    assign rf_w_ctrl  = w_nonempty ? r_regs[r_head] : '0;
    assign rf_w_data  = w_nonempty ? r_data[r_head] : '0;
    assign count      = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = rf_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_regs[r_tail] <= in_reg;
            r_data[r_tail] <= in_data;
        end
    end

`ifdef WB_FORWARD_EN
    logic [DEPTH-1:0] w_valid;

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = w_nonempty && (CNT_W'(PTR_W'(i) - r_head) < r_count);
        end
    end

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd0 (
        .i_regs  (r_regs),
        .i_data  (r_data),
        .i_valid (w_valid),
        .i_head  (r_head),
        .i_query (fwd_ctrl0),
        .o_hit   (fwd_hit0),
        .o_data  (fwd_data0)
    );

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd1 (
        .i_regs  (r_regs),
        .i_data  (r_data),
        .i_valid (w_valid),
        .i_head  (r_head),
        .i_query (fwd_ctrl1),
        .o_hit   (fwd_hit1),
        .o_data  (fwd_data1)
    );
`endif

endmodule
